// File: rtl/pcileech_com_txarb.sv
// ---------------------------------------------------------------------------
// pcileech_com_txarb
//   Round-robin packet arbiter that merges three word-streaming sources into
//   the COM TX FIFO. Each packet is framed by a header word carrying the
//   granted source index and a 16-bit sequence number. A source that goes
//   silent mid-packet is cut off after TIMEOUT_CYCLES stall cycles, and an
//   abort word is written in place of the rest of the packet.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   en              : arbitration enable (gates IDLE->HDR only)
//   src_valid[2:0]  : per-source word valid
//   src_data[2:0]   : per-source 32-bit data word
//   src_last[2:0]   : per-source last-word-of-packet flag
//   src_ready[2:0]  : per-source word accepted (combinational)
//   com_din         : registered word to the COM TX FIFO
//   com_din_wr_en   : registered write strobe to the COM TX FIFO
//   com_din_ready   : FIFO not almost-full (at least one word of slack)
//   busy            : high whenever not IDLE
//   grant           : granted source index, 2'd3 while IDLE
//   err_timeout     : one-cycle pulse when a packet is aborted
//
//   SEQ_INIT is the sequence value loaded at reset (0 in normal use).
// ---------------------------------------------------------------------------
module pcileech_com_txarb #(
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  HDR_TAG        = 8'hA5,
  parameter logic [7:0]  ABT_TAG        = 8'hAB,
  parameter logic [15:0] SEQ_INIT       = 16'h0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [2:0]      src_valid,
  input  logic [2:0][31:0] src_data,
  input  logic [2:0]      src_last,
  output logic [2:0]      src_ready,
  output logic [31:0]     com_din,
  output logic            com_din_wr_en,
  input  logic            com_din_ready,
  output logic            busy,
  output logic [1:0]      grant,
  output logic            err_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA} state_t;

  state_t           state_q, state_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       last_grant_q, last_grant_d;
  logic [15:0]      seq_q, seq_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [31:0]      din_q, din_d;
  logic             wr_q, wr_d;
  logic             err_q, err_d;

  logic sel_valid, sel_last, accept, tmo_fire;

  // First requesting source after 'last' in the order 0,1,2 (wrapping).
  // Scanning from the farthest candidate down lets the nearest one win.
  function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [2:0] req);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = 2'd0;
    for (int k = 3; k >= 1; k--) begin
      idx = 2'((int'(last) + k) % 3);
      if (req[idx]) pick = idx;
    end
    return pick;
  endfunction

  assign sel_valid = src_valid[grant_q];
  assign sel_last  = src_last[grant_q];
  assign accept    = (state_q == S_DATA) && sel_valid && com_din_ready;
  // A valid word always beats the timeout; backpressure defers the abort.
  assign tmo_fire  = (state_q == S_DATA) && !sel_valid && com_din_ready &&
                     (stall_q == STALL_MAX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd2;
      seq_q        <= SEQ_INIT;
      stall_q      <= '0;
      din_q        <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      seq_q        <= seq_d;
      stall_q      <= stall_d;
      din_q        <= din_d;
      wr_q         <= wr_d;
      err_q        <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (en && (|src_valid)) begin
          state_d = S_HDR;
          grant_d = rr_pick(last_grant_q, src_valid);
        end
      end
      S_HDR: begin
        if (com_din_ready) state_d = S_DATA;
      end
      S_DATA: begin
        if ((accept && sel_last) || tmo_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic
  always_comb begin
    src_ready    = 3'b000;
    din_d        = din_q;
    wr_d         = 1'b0;
    err_d        = 1'b0;
    seq_d        = seq_q;
    stall_d      = stall_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_HDR: begin
        if (com_din_ready) begin
          din_d   = {HDR_TAG, 6'b0, grant_q, seq_q};
          wr_d    = 1'b1;
          seq_d   = seq_q + 16'd1;
          stall_d = '0;
        end
      end
      S_DATA: begin
        src_ready[grant_q] = com_din_ready;
        if (accept) begin
          din_d   = src_data[grant_q];
          wr_d    = 1'b1;
          stall_d = '0;
          if (sel_last) last_grant_d = grant_q;
        end else if (tmo_fire) begin
          din_d        = {ABT_TAG, 6'b0, grant_q, 16'hFFFF};
          wr_d         = 1'b1;
          err_d        = 1'b1;
          last_grant_d = grant_q;
        end else if (com_din_ready) begin
          // Only reached with src_valid[grant]=0: a genuine stall cycle.
          stall_d = stall_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign com_din       = din_q;
  assign com_din_wr_en = wr_q;
  assign err_timeout   = err_q;
  assign busy          = (state_q != S_IDLE);
  assign grant         = (state_q == S_IDLE) ? 2'd3 : grant_q;

endmodule

// File: doc/pcileech_com_txarb.md
PCILEECH_COM_TXARB -- requirements
Module: pcileech_com_txarb

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: the number of stall cycles in DATA before a packet is aborted.
REQ-002 Parameter HDR_TAG, default 8'hA5: the tag byte in the header word.
REQ-003 Parameter ABT_TAG, default 8'hAB: the tag byte in the abort word.
REQ-004 clk  in  1  system clock; all logic is in this single clock domain.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 en  in  1  arbitration enable; no new grant is issued while low.
REQ-007 src_valid  in  3  per-source word valid.
REQ-008 src_data  in  3x32  per-source data word.
REQ-009 src_last  in  3  per-source last word of packet.
REQ-010 src_ready  out  3  per-source word accepted (combinational).
REQ-011 com_din  out  32  word to the COM TX FIFO (registered).
REQ-012 com_din_wr_en  out  1  write strobe to the COM TX FIFO (registered).
REQ-013 com_din_ready  in  1  COM TX FIFO not almost-full.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 grant  out  2  current source index; 2'd3 in IDLE.
REQ-016 err_timeout  out  1  one-cycle pulse on abort.

Function
REQ-017 FSM states SHALL be IDLE, HDR and DATA.
REQ-018 IDLE SHALL go to HDR when en=1 and any src_valid=1.
REQ-019 In that transition, grant SHALL be the first valid source in round-robin order starting after last_grant (order 0,1,2, wrapping).
REQ-020 src_ready SHALL be 0 in IDLE.
REQ-021 In HDR with com_din_ready=1, the block SHALL write the header word {HDR_TAG, 6'b0, grant, seq[15:0]}, increment seq (16-bit wrap) and go to DATA.
REQ-022 In HDR with com_din_ready=0, the block SHALL hold in HDR and write nothing.
REQ-023 In DATA, src_ready[grant] SHALL equal com_din_ready, and every other src_ready bit SHALL be 0.
REQ-024 Each word accepted in DATA (src_valid[grant] & src_ready[grant]) SHALL appear on com_din with com_din_wr_en=1 on the next cycle, unmodified.
REQ-025 An accepted word with src_last=1 SHALL load last_grant with grant and return the FSM to IDLE on the next cycle.
REQ-026 A new grant SHALL NOT issue until at least one IDLE cycle has elapsed, so each packet costs at least one cycle of overhead besides its header.
REQ-027 Grant SHALL be held for the whole packet; no interleaving between sources.
REQ-028 The stall counter SHALL clear on every accepted word and on entry to DATA.
REQ-029 The stall counter SHALL increment on every DATA cycle with src_valid[grant]=0, and SHALL NOT increment while com_din_ready=0 (backpressure is not a stall).
REQ-030 When the stall counter reaches TIMEOUT_CYCLES-1 and com_din_ready=1, the block SHALL write the abort word {ABT_TAG, 6'b0, grant, 16'hFFFF}, pulse err_timeout, load last_grant and go to IDLE.
REQ-031 If the stall counter has reached its limit while com_din_ready=0, the abort SHALL wait until com_din_ready=1.
REQ-032 If the timeout condition and a valid word coincide, the word SHALL take priority and the counter SHALL clear.
REQ-033 en=0 mid-packet SHALL NOT affect the packet in progress; it only blocks the IDLE->HDR transition.
REQ-034 com_din_wr_en SHALL be asserted only in the cycle after a write decision, so at most one word is written per cycle.
REQ-035 com_din_ready is an almost-full flag with at least one word of slack, so the one-cycle write latency SHALL be tolerated without overflow.

Reset
REQ-036 Reset SHALL set: state=IDLE, last_grant=2 (so source 0 has first priority), seq=0, stall counter=0.
REQ-037 Reset SHALL set the outputs to: com_din=0, com_din_wr_en=0, err_timeout=0, src_ready=0, busy=0, grant=3.
REQ-038 Reset asserted mid-packet SHALL abandon the packet with no abort word; the next cycle after reset SHALL be IDLE.

Verification
REQ-039 Stimulus: src0 sends a 2-word packet (0x11111111, 0x22222222 last) from reset. Required: com_din sequence 0xA5000000, 0x11111111, 0x22222222; then busy=0.
REQ-040 Stimulus: all three sources hold continuous 1-word packets. Required: header source field cycles 0,1,2,0 and seq increments 0,1,2,3.
REQ-041 Stimulus: com_din_ready=0 for 10 cycles mid-packet. Required: no writes during those cycles; no err_timeout; data order intact after release.
REQ-042 Stimulus: TIMEOUT_CYCLES=8; src1 valid drops after its header. Required: 0xAB01FFFF written, err_timeout pulses once, grant=3.
REQ-043 Stimulus: seq preloaded to 0xFFFF. Required: header low half is 0xFFFF, then the next header's low half is 0x0000.
REQ-044 Stimulus: rst asserted during DATA. Required: next cycle IDLE with all outputs at reset values; next grant goes to src0.
